// File: rtl/buffer_reordenamento_if.sv
// Bundle between dispatch/CDB and the reorder buffer: allocation, CDB capture,
// operand lookup, flush and the in-order commit port.
interface buffer_reordenamento_if #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
);
    logic              Alloc_valid;
    logic [REG_W-1:0]  Alloc_R_target;
    logic [TAG_W-1:0]  Alloc_tag;
    logic              Full;
    logic              Empty;
    logic [TAG_W-1:0]  Count;
    logic              Write_Enable_CDB;
    logic [TAG_W-1:0]  Qi_CDB;
    logic [DATA_W-1:0] Qi_CDB_data;
    logic [TAG_W-1:0]  Lookup_tag;
    logic              Lookup_ready;
    logic [DATA_W-1:0] Lookup_data;
    logic              Flush;
    logic              Commit_valid;
    logic [TAG_W-1:0]  Commit_tag;
    logic [REG_W-1:0]  Commit_R_target;
    logic [DATA_W-1:0] Commit_data;

    modport master (
        output Alloc_valid, Alloc_R_target, Write_Enable_CDB, Qi_CDB, Qi_CDB_data,
               Lookup_tag, Flush,
        input  Alloc_tag, Full, Empty, Count, Lookup_ready, Lookup_data,
               Commit_valid, Commit_tag, Commit_R_target, Commit_data
    );

    modport slave (
        input  Alloc_valid, Alloc_R_target, Write_Enable_CDB, Qi_CDB, Qi_CDB_data,
               Lookup_tag, Flush,
        output Alloc_tag, Full, Empty, Count, Lookup_ready, Lookup_data,
               Commit_valid, Commit_tag, Commit_R_target, Commit_data
    );
endinterface

// File: rtl/buffer_reordenamento.sv
// In-order commit buffer: entries are allocated at dispatch, filled from the CDB
// by tag (entry i <-> tag i+1), and retired one per cycle from the head.
module buffer_reordenamento #(
    parameter int                 DEPTH     = 4,
    parameter int                 TAG_W     = 3,
    parameter int                 DATA_W    = 16,
    parameter int                 REG_W     = 4,
    parameter logic [DATA_W-1:0]  SEM_VALOR = 16'hFFF0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    buffer_reordenamento_if.slave  bus
);
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [TAG_W-1:0]  DEPTH_TAG = TAG_W'(DEPTH);
    localparam logic [TAG_W-1:0]  ONE_TAG   = TAG_W'(1);

    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  ready_reg;
    logic [REG_W-1:0]  rtarget_reg [DEPTH];
    logic [DATA_W-1:0] data_reg    [DEPTH];
    logic [IDX_W-1:0]  head_reg;
    logic [IDX_W-1:0]  tail_reg;
    logic [TAG_W-1:0]  count_reg;

    logic              commit_valid_reg;
    logic [TAG_W-1:0]  commit_tag_reg;
    logic [REG_W-1:0]  commit_rtarget_reg;
    logic [DATA_W-1:0] commit_data_reg;

    logic              full;
    logic              alloc_accept;
    logic              commit_fire;
    logic              cdb_tag_ok;
    logic [IDX_W-1:0]  cdb_idx;
    logic              cdb_capture;
    logic              lookup_tag_ok;
    logic [IDX_W-1:0]  lookup_idx;
    logic [DEPTH-1:0]  alloc_sel;
    logic [DEPTH-1:0]  commit_sel;
    logic [DEPTH-1:0]  cdb_sel;

    assign full         = (count_reg == DEPTH_TAG);
    assign alloc_accept = bus.Alloc_valid && !full;
    assign commit_fire  = busy_reg[head_reg] && ready_reg[head_reg];

    // Tag 0 and tags beyond DEPTH never name an entry.
    assign cdb_tag_ok  = (bus.Qi_CDB != '0) && (bus.Qi_CDB <= DEPTH_TAG);
    assign cdb_idx     = IDX_W'(bus.Qi_CDB - ONE_TAG);
    assign cdb_capture = bus.Write_Enable_CDB && cdb_tag_ok &&
                         busy_reg[cdb_idx] && !ready_reg[cdb_idx];

    assign lookup_tag_ok = (bus.Lookup_tag != '0) && (bus.Lookup_tag <= DEPTH_TAG);
    assign lookup_idx    = IDX_W'(bus.Lookup_tag - ONE_TAG);

    always_comb begin
        bus.Lookup_ready = 1'b0;
        bus.Lookup_data  = SEM_VALOR;
        if (lookup_tag_ok && busy_reg[lookup_idx] && ready_reg[lookup_idx]) begin
            bus.Lookup_ready = 1'b1;
            bus.Lookup_data  = data_reg[lookup_idx];
        end
    end

    // Per-entry write selects; allocate/commit/capture are mutually exclusive
    // on any one entry (allocate needs !busy, capture needs !ready, commit needs ready).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign alloc_sel[gi]  = alloc_accept && (tail_reg == IDX_W'(gi));
            assign commit_sel[gi] = commit_fire  && (head_reg == IDX_W'(gi));
            assign cdb_sel[gi]    = cdb_capture  && (cdb_idx  == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (!Reset || bus.Flush) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            busy_reg         <= '0;
            ready_reg        <= '0;
            commit_valid_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rtarget_reg[i] <= '0;
                data_reg[i]    <= SEM_VALOR;
            end
            if (!Reset) begin
                commit_tag_reg     <= '0;
                commit_rtarget_reg <= '0;
                commit_data_reg    <= SEM_VALOR;
            end
        end else begin
            if (alloc_accept)
                tail_reg <= (tail_reg == LAST_IDX) ? '0 : tail_reg + IDX_W'(1);
            if (commit_fire) begin
                head_reg           <= (head_reg == LAST_IDX) ? '0 : head_reg + IDX_W'(1);
                commit_tag_reg     <= TAG_W'(head_reg) + ONE_TAG;
                commit_rtarget_reg <= rtarget_reg[head_reg];
                commit_data_reg    <= data_reg[head_reg];
            end
            commit_valid_reg <= commit_fire;
            count_reg        <= count_reg + TAG_W'(alloc_accept) - TAG_W'(commit_fire);

            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_sel[i]) begin
                    busy_reg[i]    <= 1'b1;
                    ready_reg[i]   <= 1'b0;
                    rtarget_reg[i] <= bus.Alloc_R_target;
                    data_reg[i]    <= SEM_VALOR;
                end else if (commit_sel[i]) begin
                    busy_reg[i]  <= 1'b0;
                    ready_reg[i] <= 1'b0;
                    data_reg[i]  <= SEM_VALOR;
                end else if (cdb_sel[i]) begin
                    ready_reg[i] <= 1'b1;
                    data_reg[i]  <= bus.Qi_CDB_data;
                end
            end
        end
    end

    assign bus.Full            = full;
    assign bus.Empty           = (count_reg == '0);
    assign bus.Count           = count_reg;
    assign bus.Alloc_tag       = TAG_W'(tail_reg) + ONE_TAG;
    assign bus.Commit_valid    = commit_valid_reg;
    assign bus.Commit_tag      = commit_tag_reg;
    assign bus.Commit_R_target = commit_rtarget_reg;
    assign bus.Commit_data     = commit_data_reg;
endmodule

// File: tb/tb_buffer_reordenamento.sv
// Bench for buffer_reordenamento: directed scenarios then random traffic, all
// checked against a program-order queue model of the buffer.
module tb_buffer_reordenamento;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] SEM    = 16'hFFF0;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    buffer_reordenamento_if #(.TAG_W(3), .DATA_W(16), .REG_W(4)) bus ();

    buffer_reordenamento #(
        .DEPTH(DEPTH), .TAG_W(3), .DATA_W(16), .REG_W(4), .SEM_VALOR(SEM)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          tag;
        logic [3:0]  rt;
        bit          rdy;
        logic [15:0] data;
    } ent_t;

    ent_t        q[$];
    int          next_tag = 1;
    bit          model_known = 0;
    logic        exp_cv;
    logic [2:0]  exp_ct;
    logic [3:0]  exp_crt;
    logic [15:0] exp_cd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit rst_n, input bit av, input logic [3:0] art,
                                input bit we, input logic [2:0] qt, input logic [15:0] qd,
                                input bit fl);
        bit   was_full;
        bit   do_commit;
        ent_t e;
        if (!rst_n || fl) begin
            q.delete();
            next_tag = 1;
            exp_cv   = 1'b0;
            if (!rst_n) begin
                exp_ct      = 3'd0;
                exp_crt     = 4'd0;
                exp_cd      = SEM;
                model_known = 1;
            end
        end else begin
            was_full  = (q.size() == DEPTH);
            do_commit = (q.size() > 0) && q[0].rdy;
            if (we)
                foreach (q[i])
                    if (q[i].tag == int'(qt) && !q[i].rdy) begin
                        q[i].rdy  = 1;
                        q[i].data = qd;
                    end
            if (do_commit) begin
                e       = q.pop_front();
                exp_cv  = 1'b1;
                exp_ct  = 3'(e.tag);
                exp_crt = e.rt;
                exp_cd  = e.data;
            end else begin
                exp_cv = 1'b0;
            end
            if (av && !was_full) begin
                e.tag  = next_tag;
                e.rt   = art;
                e.rdy  = 0;
                e.data = SEM;
                q.push_back(e);
                next_tag = (next_tag == DEPTH) ? 1 : next_tag + 1;
            end
        end
    endtask

    // One clock of stimulus: check pre-edge combinational outputs, clock it,
    // then check the registered commit port.
    task automatic step(input bit rst_n, input bit av, input logic [3:0] art,
                        input bit we, input logic [2:0] qt, input logic [15:0] qd,
                        input logic [2:0] lt, input bit fl);
        bit          l_rdy;
        logic [15:0] l_data;
        Reset                = rst_n;
        bus.Alloc_valid      = av;
        bus.Alloc_R_target   = art;
        bus.Write_Enable_CDB = we;
        bus.Qi_CDB           = qt;
        bus.Qi_CDB_data      = qd;
        bus.Lookup_tag       = lt;
        bus.Flush            = fl;
        #1;
        if (model_known) begin
            l_rdy  = 0;
            l_data = SEM;
            foreach (q[i])
                if (q[i].tag == int'(lt) && q[i].rdy) begin
                    l_rdy  = 1;
                    l_data = q[i].data;
                end
            check("count",        32'(bus.Count),        32'(q.size()));
            check("full",         32'(bus.Full),         32'(q.size() == DEPTH));
            check("empty",        32'(bus.Empty),        32'(q.size() == 0));
            check("alloc_tag",    32'(bus.Alloc_tag),    32'(next_tag));
            check("lookup_ready", 32'(bus.Lookup_ready), 32'(l_rdy));
            check("lookup_data",  32'(bus.Lookup_data),  32'(l_data));
        end
        @(posedge Clock);
        model_update(rst_n, av, art, we, qt, qd, fl);
        @(negedge Clock);
        if (model_known) begin
            check("commit_valid",   32'(bus.Commit_valid),    32'(exp_cv));
            check("commit_tag",     32'(bus.Commit_tag),      32'(exp_ct));
            check("commit_rtarget", 32'(bus.Commit_R_target), 32'(exp_crt));
            check("commit_data",    32'(bus.Commit_data),     32'(exp_cd));
        end
    endtask

    task automatic idle(input logic [2:0] lt);
        step(1, 0, 4'd0, 0, 3'd0, 16'h0, lt, 0);
    endtask

    initial begin
        bit          r_rst, r_av, r_we, r_fl;
        logic [2:0]  r_qt;
        bus.Alloc_valid      = 0;
        bus.Alloc_R_target   = '0;
        bus.Write_Enable_CDB = 0;
        bus.Qi_CDB           = '0;
        bus.Qi_CDB_data      = '0;
        bus.Lookup_tag       = '0;
        bus.Flush            = 0;
        @(negedge Clock);

        // reset for two cycles
        step(0, 0, 4'd0, 0, 3'd0, 16'h0, 3'd0, 0);
        step(0, 0, 4'd0, 0, 3'd0, 16'h0, 3'd0, 0);

        // single allocate / capture / commit
        step(1, 1, 4'd3, 0, 3'd0, 16'h0, 3'd1, 0);
        step(1, 0, 4'd0, 1, 3'd1, 16'h0007, 3'd1, 0);
        idle(3'd1);
        idle(3'd1);

        // out-of-order completion, in-order retirement
        step(1, 0, 4'd0, 0, 3'd0, 16'h0, 3'd0, 1);
        step(1, 1, 4'd1, 0, 3'd0, 16'h0, 3'd0, 0);
        step(1, 1, 4'd2, 0, 3'd0, 16'h0, 3'd0, 0);
        step(1, 0, 4'd0, 1, 3'd2, 16'h0005, 3'd2, 0);
        step(1, 0, 4'd0, 1, 3'd1, 16'h0009, 3'd2, 0);
        idle(3'd1);
        idle(3'd2);
        idle(3'd0);

        // fill, overflow, wrap
        step(1, 0, 4'd0, 0, 3'd0, 16'h0, 3'd0, 1);
        for (int i = 0; i < 5; i++)
            step(1, 1, 4'(4 + i), 0, 3'd0, 16'h0, 3'd0, 0);
        step(1, 1, 4'd9, 1, 3'd1, 16'h0100, 3'd1, 0);
        step(1, 1, 4'd9, 1, 3'd2, 16'h0200, 3'd1, 0);
        step(1, 1, 4'd10, 0, 3'd0, 16'h0, 3'd2, 0);
        idle(3'd1);
        idle(3'd0);

        // ignored CDB writes
        step(1, 0, 4'd0, 0, 3'd0, 16'h0, 3'd0, 1);
        step(1, 1, 4'd1, 0, 3'd0, 16'h0, 3'd0, 0);
        step(1, 1, 4'd2, 1, 3'd2, 16'h0044, 3'd2, 0);
        step(1, 0, 4'd0, 1, 3'd2, 16'h0011, 3'd2, 0);
        step(1, 0, 4'd0, 1, 3'd2, 16'h0022, 3'd2, 0);
        step(1, 0, 4'd0, 1, 3'd0, 16'h0033, 3'd2, 0);
        step(1, 0, 4'd0, 1, 3'd6, 16'h0066, 3'd6, 0);
        step(1, 0, 4'd0, 1, 3'd3, 16'h0077, 3'd3, 0);
        step(1, 0, 4'd0, 1, 3'd1, 16'h0055, 3'd2, 0);
        idle(3'd1);
        idle(3'd2);
        idle(3'd0);

        // flush with busy entries and a concurrent CDB write
        step(1, 0, 4'd0, 0, 3'd0, 16'h0, 3'd0, 1);
        step(1, 1, 4'd5, 0, 3'd0, 16'h0, 3'd0, 0);
        step(1, 1, 4'd6, 0, 3'd0, 16'h0, 3'd0, 0);
        step(1, 1, 4'd7, 1, 3'd1, 16'h00AA, 3'd0, 0);
        step(1, 1, 4'd8, 1, 3'd2, 16'h00BB, 3'd1, 1);
        idle(3'd1);

        // reset on the edge a commit would occur
        step(1, 1, 4'd2, 0, 3'd0, 16'h0, 3'd0, 0);
        step(1, 0, 4'd0, 1, 3'd1, 16'h00CC, 3'd1, 0);
        step(0, 1, 4'd4, 1, 3'd1, 16'h00DD, 3'd1, 0);
        idle(3'd1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            r_rst = ($urandom_range(0, 99) != 0);
            r_fl  = ($urandom_range(0, 99) < 2);
            r_av  = ($urandom_range(0, 99) < 55);
            r_we  = ($urandom_range(0, 99) < 70);
            r_qt  = ($urandom_range(0, 99) < 85) ? 3'($urandom_range(1, DEPTH))
                                                 : 3'($urandom_range(0, 7));
            step(r_rst, r_av, 4'($urandom), r_we, r_qt, 16'($urandom),
                 3'($urandom_range(0, 7)), r_fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
